// File: rtl/reaction_time_counter.sv
// Millisecond reaction-time counter: 4-digit BCD elapsed time driven by the game's
// CounterFlag/ErrorFlag pair, with a one-cycle result pulse and a best-time register.
module reaction_time_counter #(
  parameter int TICK_DIV = 50000,
  parameter int TICK_W   = 16
) (
  input  logic        clk_50M,
  input  logic        clear,
  input  logic [1:0]  CounterFlag,
  input  logic        ErrorFlag,
  output logic [15:0] CounterOut,
  output logic        Overflow,
  output logic        Running,
  output logic        ResultValid,
  output logic [15:0] BestTime,
  output logic        BestValid
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
  localparam logic [1:0] FLAG_CLEAR = 2'b00;
  localparam logic [1:0] FLAG_STOP  = 2'b01;
  localparam logic [1:0] FLAG_RUN   = 2'b10;

  state_t            state;
  logic [1:0]        prev_flag;
  logic [TICK_W-1:0] prescaler;
  logic [15:0]       count_inc;
  logic              tick;
  logic              result_ok;

  // NOTE: every variable written in always_comb gets a default first, so no
  // path can leave it unassigned and infer a latch.
  always_comb begin : bcd_next
    logic carry;
    count_inc = CounterOut;
    carry     = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (carry) begin
        if (CounterOut[4*i +: 4] == 4'd9) begin
          count_inc[4*i +: 4] = 4'd0;
        end else begin
          count_inc[4*i +: 4] = CounterOut[4*i +: 4] + 4'd1;
          carry               = 1'b0;
        end
      end
    end
  end

  assign tick      = (prescaler == TICK_LAST);
  // Only a genuine 10 -> 01 stop with no foul and no saturation is a result.
  assign result_ok = (prev_flag == FLAG_RUN) && !ErrorFlag && !Overflow;
  assign Running   = (state == RUN);

  // NOTE: sequential state uses non-blocking assignments only, so every
  // right-hand side reads the value from before this clock edge.
  always_ff @(posedge clk_50M) begin
    if (clear) begin
      state       <= IDLE;
      prev_flag   <= FLAG_CLEAR;
      prescaler   <= '0;
      CounterOut  <= 16'h0000;
      Overflow    <= 1'b0;
      ResultValid <= 1'b0;
      BestTime    <= 16'h9999;
      BestValid   <= 1'b0;
    end else begin
      ResultValid <= 1'b0;
      prev_flag   <= CounterFlag;
      case (CounterFlag)
        FLAG_CLEAR: begin
          state      <= IDLE;
          prescaler  <= '0;
          CounterOut <= 16'h0000;
          Overflow   <= 1'b0;
        end
        FLAG_RUN: begin
          state <= RUN;
          if (prev_flag != FLAG_RUN) begin
            prescaler  <= '0;
            CounterOut <= 16'h0000;
            Overflow   <= 1'b0;
          end else if (tick) begin
            prescaler <= '0;
            if (CounterOut == 16'h9999) Overflow <= 1'b1;
            else                        CounterOut <= count_inc;
          end else begin
            prescaler <= prescaler + 1'b1;
          end
        end
        FLAG_STOP: begin
          state <= HOLD;
          if (result_ok) begin
            ResultValid <= 1'b1;
            if (CounterOut < BestTime) begin
              BestTime  <= CounterOut;
              BestValid <= 1'b1;
            end
          end
        end
        default: begin
          // Illegal 11 freezes like a stop but never reports a result.
          state <= HOLD;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reaction_time_counter.sv
// Self-checking bench for reaction_time_counter: table-driven vectors on a TICK_DIV=10
// instance plus hand-written overflow and dropped-tick sequences on TICK_DIV=2/10.
module tb_reaction_time_counter;

  logic        clk_50M = 1'b0;
  logic        clear = 1'b1;
  logic [1:0]  CounterFlag = 2'b00;
  logic        ErrorFlag = 1'b0;

  logic [15:0] cnt1, best1, cnt2, best2;
  logic        ovf1, run1, rv1, bv1, ovf2, run2, rv2, bv2;

  int checks = 0;
  int errors = 0;

  always #10 clk_50M = ~clk_50M;

  reaction_time_counter #(.TICK_DIV(10), .TICK_W(16)) dut1 (
    .clk_50M(clk_50M), .clear(clear), .CounterFlag(CounterFlag), .ErrorFlag(ErrorFlag),
    .CounterOut(cnt1), .Overflow(ovf1), .Running(run1), .ResultValid(rv1),
    .BestTime(best1), .BestValid(bv1)
  );

  reaction_time_counter #(.TICK_DIV(2), .TICK_W(4)) dut2 (
    .clk_50M(clk_50M), .clear(clear), .CounterFlag(CounterFlag), .ErrorFlag(ErrorFlag),
    .CounterOut(cnt2), .Overflow(ovf2), .Running(run2), .ResultValid(rv2),
    .BestTime(best2), .BestValid(bv2)
  );

  typedef struct {
    int          n;
    logic        clr;
    logic [1:0]  flag;
    logic        err;
    logic [15:0] cnt;
    logic        ovf;
    logic        run;
    logic        rv;
    logic [15:0] best;
    logic        bv;
  } vec_t;

  vec_t vecs[64];
  int   nvec = 0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cyc(input logic clr, input logic [1:0] flag, input logic err);
    clear       = clr;
    CounterFlag = flag;
    ErrorFlag   = err;
    @(posedge clk_50M);
    #1;
  endtask

  task automatic add(input int n, input logic clr, input logic [1:0] flag, input logic err,
                     input logic [15:0] cnt, input logic ovf, input logic run, input logic rv,
                     input logic [15:0] best, input logic bv);
    vecs[nvec] = '{n, clr, flag, err, cnt, ovf, run, rv, best, bv};
    nvec++;
  endtask

  // Decimal reference for the BCD successor: decode, add one, re-encode.
  function automatic logic [15:0] bcd_succ(input logic [15:0] b);
    int v;
    v = 1000 * int'(b[15:12]) + 100 * int'(b[11:8]) + 10 * int'(b[7:4]) + int'(b[3:0]);
    v = v + 1;
    return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  logic [15:0] prev_cnt;
  int          bad_incs;
  logic        seen_99, seen_999;

  initial begin
    // ---------------- overflow run on the TICK_DIV=2 instance ----------------
    cyc(1'b1, 2'b00, 1'b0);
    cyc(1'b1, 2'b00, 1'b0);
    check("ovf reset count", cnt2, 16'h0000);
    check("ovf reset best", best2, 16'h9999);
    prev_cnt = 16'h0000;
    bad_incs = 0;
    seen_99  = 1'b0;
    seen_999 = 1'b0;
    for (int k = 0; k < 20010; k++) begin
      cyc(1'b0, 2'b10, 1'b0);
      if (cnt2 !== prev_cnt) begin
        if (cnt2 !== bcd_succ(prev_cnt)) bad_incs++;
        if (prev_cnt == 16'h0099 && cnt2 == 16'h0100) seen_99 = 1'b1;
        if (prev_cnt == 16'h0999 && cnt2 == 16'h1000) seen_999 = 1'b1;
      end
      prev_cnt = cnt2;
    end
    check("ovf bad increments", 16'(bad_incs), 16'd0);
    check("ovf carry 0099->0100", 16'(seen_99), 16'd1);
    check("ovf carry 0999->1000", 16'(seen_999), 16'd1);
    check("ovf saturated count", cnt2, 16'h9999);
    check("ovf flag", 16'(ovf2), 16'd1);
    check("ovf running", 16'(run2), 16'd1);
    cyc(1'b0, 2'b01, 1'b0);
    check("ovf stop no pulse", 16'(rv2), 16'd0);
    check("ovf stop best", best2, 16'h9999);
    check("ovf stop bestvalid", 16'(bv2), 16'd0);
    check("ovf held in hold", 16'(ovf2), 16'd1);
    check("ovf count held", cnt2, 16'h9999);
    cyc(1'b0, 2'b10, 1'b0);
    check("ovf cleared on reentry", 16'(ovf2), 16'd0);
    check("ovf count cleared on reentry", cnt2, 16'h0000);

    // ---------------- table-driven vectors on the TICK_DIV=10 instance ----------------
    //  n   clr flag   err  cnt       ovf  run  rv   best      bv
    add(2,  1, 2'b00, 0, 16'h0000, 0, 0, 0, 16'h9999, 0);
    add(1,  0, 2'b10, 0, 16'h0000, 0, 1, 0, 16'h9999, 0);
    add(34, 0, 2'b10, 0, 16'h0003, 0, 1, 0, 16'h9999, 0);
    add(1,  0, 2'b01, 0, 16'h0003, 0, 0, 1, 16'h0003, 1);
    add(1,  0, 2'b01, 0, 16'h0003, 0, 0, 0, 16'h0003, 1);
    // three runs re-entered directly from hold
    add(1,  1, 2'b00, 0, 16'h0000, 0, 0, 0, 16'h9999, 0);
    add(1,  0, 2'b10, 0, 16'h0000, 0, 1, 0, 16'h9999, 0);
    add(70, 0, 2'b10, 0, 16'h0007, 0, 1, 0, 16'h9999, 0);
    add(1,  0, 2'b01, 0, 16'h0007, 0, 0, 1, 16'h0007, 1);
    add(1,  0, 2'b10, 0, 16'h0000, 0, 1, 0, 16'h0007, 1);
    add(40, 0, 2'b10, 0, 16'h0004, 0, 1, 0, 16'h0007, 1);
    add(1,  0, 2'b01, 0, 16'h0004, 0, 0, 1, 16'h0004, 1);
    add(1,  0, 2'b10, 0, 16'h0000, 0, 1, 0, 16'h0004, 1);
    add(90, 0, 2'b10, 0, 16'h0009, 0, 1, 0, 16'h0004, 1);
    add(1,  0, 2'b01, 0, 16'h0009, 0, 0, 1, 16'h0004, 1);
    add(1,  0, 2'b01, 0, 16'h0009, 0, 0, 0, 16'h0004, 1);
    // equal time: pulse, no best change
    add(1,  0, 2'b10, 0, 16'h0000, 0, 1, 0, 16'h0004, 1);
    add(40, 0, 2'b10, 0, 16'h0004, 0, 1, 0, 16'h0004, 1);
    add(1,  0, 2'b01, 0, 16'h0004, 0, 0, 1, 16'h0004, 1);
    // foul stop
    add(1,  0, 2'b10, 0, 16'h0000, 0, 1, 0, 16'h0004, 1);
    add(54, 0, 2'b10, 0, 16'h0005, 0, 1, 0, 16'h0004, 1);
    add(1,  0, 2'b01, 1, 16'h0005, 0, 0, 0, 16'h0004, 1);
    add(1,  0, 2'b01, 0, 16'h0005, 0, 0, 0, 16'h0004, 1);
    // 00 mid-run keeps best
    add(1,  0, 2'b10, 0, 16'h0000, 0, 1, 0, 16'h0004, 1);
    add(30, 0, 2'b10, 0, 16'h0003, 0, 1, 0, 16'h0004, 1);
    add(1,  0, 2'b00, 0, 16'h0000, 0, 0, 0, 16'h0004, 1);
    // clear mid-run wins over flag=10
    add(1,  0, 2'b10, 0, 16'h0000, 0, 1, 0, 16'h0004, 1);
    add(60, 0, 2'b10, 0, 16'h0006, 0, 1, 0, 16'h0004, 1);
    add(1,  1, 2'b10, 0, 16'h0000, 0, 0, 0, 16'h9999, 0);
    // foul from idle, then 11 during run
    add(1,  0, 2'b01, 1, 16'h0000, 0, 0, 0, 16'h9999, 0);
    add(1,  0, 2'b01, 0, 16'h0000, 0, 0, 0, 16'h9999, 0);
    add(1,  0, 2'b10, 0, 16'h0000, 0, 1, 0, 16'h9999, 0);
    add(20, 0, 2'b10, 0, 16'h0002, 0, 1, 0, 16'h9999, 0);
    add(1,  0, 2'b11, 0, 16'h0002, 0, 0, 0, 16'h9999, 0);
    add(15, 0, 2'b11, 0, 16'h0002, 0, 0, 0, 16'h9999, 0);
    add(1,  0, 2'b01, 0, 16'h0002, 0, 0, 0, 16'h9999, 0);
    add(1,  0, 2'b10, 0, 16'h0000, 0, 1, 0, 16'h9999, 0);

    for (int i = 0; i < nvec; i++) begin
      for (int c = 0; c < vecs[i].n; c++) cyc(vecs[i].clr, vecs[i].flag, vecs[i].err);
      check($sformatf("v%0d count", i), cnt1, vecs[i].cnt);
      check($sformatf("v%0d overflow", i), 16'(ovf1), 16'(vecs[i].ovf));
      check($sformatf("v%0d running", i), 16'(run1), 16'(vecs[i].run));
      check($sformatf("v%0d resultvalid", i), 16'(rv1), 16'(vecs[i].rv));
      check($sformatf("v%0d besttime", i), best1, vecs[i].best);
      check($sformatf("v%0d bestvalid", i), 16'(bv1), 16'(vecs[i].bv));
    end

    // ---------------- tick due in the first stop cycle is dropped ----------------
    cyc(1'b1, 2'b00, 1'b0);
    cyc(1'b0, 2'b10, 1'b0);
    for (int k = 0; k < 9; k++) cyc(1'b0, 2'b10, 1'b0);
    check("drop pre-stop count", cnt1, 16'h0000);
    cyc(1'b0, 2'b01, 1'b0);
    check("drop stop count", cnt1, 16'h0000);
    check("drop stop pulse", 16'(rv1), 16'd1);
    check("drop stop best", best1, 16'h0000);
    cyc(1'b0, 2'b01, 1'b0);
    check("drop hold count", cnt1, 16'h0000);
    check("drop pulse one cycle", 16'(rv1), 16'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
